// File: rtl/phase_sequence_counter.sv
// phase_sequence_counter
//   N-phase sequence counter. A run latch gates a modulo-PHASES counter, and
//   the count is decoded to a one-hot phase bus that drives ALU micro-steps.
//
//   Parameters
//     PHASES     number of phases, 2..32
//     STOP_MODE  0 = stop at once on end_signal_i
//                1 = finish the current cycle and stop at the wrap to phase 0
//
//   Ports
//     clk_i           clock; all state changes on the rising edge
//     reset_i         synchronous reset, active low
//     begin_signal_i  start request (sets the run latch)
//     end_signal_i    stop request; wins over begin_signal_i
//     hold_i          stall; the count does not advance while high
//     running_o       run latch state
//     count_o         current phase index, 0..PHASES-1
//     phase_o         one-hot decode of count_o, also valid while idle
//     last_phase_o    running and count at PHASES-1
//     cycle_done_o    one-cycle pulse after the count wraps PHASES-1 -> 0
//     cycles_o        completed-cycle counter, saturating at 16'hFFFF
//                     (present only when SEQ_CYCLE_COUNT_EN is defined)
//
//   Build option SEQ_CYCLE_COUNT_EN adds cycles_o. It is cleared by reset and
//   by a start that is accepted while idle.
//
//   state         | meaning
//   --------------+-------------------------------------------------------
//   ST_IDLE       | run latch clear; the count is frozen
//   ST_RUN        | run latch set; the count advances unless held
//   ST_STOP_PEND  | still running; the stop takes effect at the next wrap
//                 | (reachable only when STOP_MODE is 1)
module phase_sequence_counter #(
  parameter int PHASES    = 5,
  parameter int STOP_MODE = 0,
  localparam int CNT_W    = $clog2(PHASES)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              begin_signal_i,
  input  logic              end_signal_i,
  input  logic              hold_i,
  output logic              running_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [PHASES-1:0] phase_o,
  output logic              last_phase_o,
  output logic              cycle_done_o
`ifdef SEQ_CYCLE_COUNT_EN
  ,
  output logic [15:0]       cycles_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STOP_PEND = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cycle_done_q;
  logic             running;
  logic             at_last;
  logic             advance;
  logic             wrap;
  logic             start_req;

  assign running   = (state_q != ST_IDLE);
  assign at_last   = (count_q == CNT_W'(PHASES - 1));
  // The counter sees the registered run latch, so a start sampled at one edge
  // first advances the count at the following edge.
  assign advance   = running && !hold_i;
  assign wrap      = advance && at_last;
  assign start_req = begin_signal_i && !end_signal_i;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (advance) begin
      count_d = at_last ? '0 : count_q + CNT_W'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (start_req) state_d = ST_RUN;
      end
      ST_RUN: begin
        // An end request that lands on the wrap edge in stop-at-wrap mode
        // stops right there: the count is already going back to 0.
        if (end_signal_i) begin
          if ((STOP_MODE == 0) || wrap) state_d = ST_IDLE;
          else                          state_d = ST_STOP_PEND;
        end
      end
      ST_STOP_PEND: begin
        // A fresh start request cancels the pending stop.
        if (start_req)  state_d = ST_RUN;
        else if (wrap)  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      cycle_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      cycle_done_q <= wrap;
    end
  end

  always_comb begin
    phase_o = '0;
    for (int i = 0; i < PHASES; i++) begin
      phase_o[i] = (count_q == CNT_W'(i));
    end
  end

  assign running_o    = running;
  assign count_o      = count_q;
  assign last_phase_o = running && at_last;
  assign cycle_done_o = cycle_done_q;

`ifdef SEQ_CYCLE_COUNT_EN
  logic [15:0] cycles_q, cycles_d;

  // A start accepted while idle and a wrap can never share an edge, because a
  // wrap needs the run latch already set.
  always_comb begin
    cycles_d = cycles_q;
    if ((state_q == ST_IDLE) && start_req) begin
      cycles_d = '0;
    end else if (wrap && (cycles_q != 16'hFFFF)) begin
      cycles_d = cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) cycles_q <= '0;
    else          cycles_q <= cycles_d;
  end

  assign cycles_o = cycles_q;
`endif

endmodule
